// File: rtl/mastermind_pkg.sv
// Shared constants, feedback codes and FSM encoding for the Mastermind/Wordle scorer.
// Also used by the game core, so changes here ripple beyond the scorer.
package mastermind_pkg;

  localparam int unsigned N_PEGS    = 4;
  localparam int unsigned COLOR_W   = 3;
  localparam int unsigned N_ROWS    = 6;
  localparam int unsigned FB_W      = 2;
  localparam int unsigned ROW_W     = 3;
  localparam int unsigned PEG_IDX_W = 2;

  localparam int unsigned GUESS_W  = N_PEGS * COLOR_W;
  localparam int unsigned FB_ROW_W = N_PEGS * FB_W;
  localparam int unsigned FLAT_W   = N_ROWS * FB_ROW_W;

  localparam logic [COLOR_W-1:0] COLOR_NONE = '0;

  localparam logic [FB_W-1:0] FB_EMPTY   = 2'b00;
  localparam logic [FB_W-1:0] FB_ABSENT  = 2'b01;
  localparam logic [FB_W-1:0] FB_PRESENT = 2'b10;
  localparam logic [FB_W-1:0] FB_EXACT   = 2'b11;

  localparam logic [FB_ROW_W-1:0] FB_ALL_EXACT = {N_PEGS{FB_EXACT}};
  localparam logic [ROW_W-1:0]    ROW_LIMIT    = ROW_W'(N_ROWS);
  localparam logic [PEG_IDX_W-1:0] LAST_PEG    = PEG_IDX_W'(N_PEGS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StExact,
    StPartial,
    StCommit
  } state_e;

  function automatic logic [COLOR_W-1:0] peg_color(logic [GUESS_W-1:0]   v,
                                                   logic [PEG_IDX_W-1:0] idx);
    return v[int'(idx) * COLOR_W +: COLOR_W];
  endfunction

endpackage

// File: rtl/mastermind_match_find.sv
// Combinational search for the lowest-index unused answer slot holding a given colour.
// Colour 0 is "unselected" and never matches.
module mastermind_match_find
  import mastermind_pkg::*;
(
  input  logic [GUESS_W-1:0]   answer_i,
  input  logic [N_PEGS-1:0]    used_i,
  input  logic [COLOR_W-1:0]   color_i,
  output logic                 found_o,
  output logic [PEG_IDX_W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int j = N_PEGS - 1; j >= 0; j--) begin
      if (!used_i[j] && (color_i != COLOR_NONE) &&
          (answer_i[j * COLOR_W +: COLOR_W] == color_i)) begin
        found_o = 1'b1;
        idx_o   = PEG_IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential guess scorer: exact pass then partial pass, one peg per cycle, then commits
// the feedback row into the renderer matrix and updates the sticky solved flag.
module mastermind_scorer
  import mastermind_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 reset_db,
  input  logic                 start_i,
  input  logic [GUESS_W-1:0]   guess_i,
  input  logic [GUESS_W-1:0]   answer_i,
  input  logic [ROW_W-1:0]     row_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 solved_o,
  output logic [FB_ROW_W-1:0]  last_fb_o,
  output logic [FLAT_W-1:0]    fb_flat_o
);

  state_e state_q, state_d;

  logic [PEG_IDX_W-1:0] k_q, k_d;
  logic [GUESS_W-1:0]   guess_q, guess_d;
  logic [GUESS_W-1:0]   answer_q, answer_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [N_PEGS-1:0]    used_q, used_d;
  logic [FB_ROW_W-1:0]  fb_q, fb_d;
  logic                 done_q, done_d;
  logic                 solved_q, solved_d;
  logic [FB_ROW_W-1:0]  last_fb_q, last_fb_d;
  logic [FLAT_W-1:0]    fb_flat_q, fb_flat_d;

  logic capture_en, exact_en, partial_en, commit_en, busy;

  logic [COLOR_W-1:0]   g_k, a_k;
  logic [FB_W-1:0]      fb_k;
  logic                 match_found;
  logic [PEG_IDX_W-1:0] match_idx;

  assign g_k  = peg_color(guess_q, k_q);
  assign a_k  = peg_color(answer_q, k_q);
  assign fb_k = fb_q[{k_q, 1'b0} +: FB_W];

  mastermind_match_find u_match_find (
    .answer_i (answer_q),
    .used_i   (used_q),
    .color_i  (g_k),
    .found_o  (match_found),
    .idx_o    (match_idx)
  );

  // FSM state register
  always_ff @(posedge sys_clk or posedge reset_db) begin
    if (reset_db) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_i) state_d = StExact;
      StExact:   if (k_q == LAST_PEG) state_d = StPartial;
      StPartial: if (k_q == LAST_PEG) state_d = StCommit;
      StCommit:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    capture_en = 1'b0;
    exact_en   = 1'b0;
    partial_en = 1'b0;
    commit_en  = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      StIdle:    capture_en = start_i;
      StExact:   begin busy = 1'b1; exact_en   = 1'b1; end
      StPartial: begin busy = 1'b1; partial_en = 1'b1; end
      StCommit:  begin busy = 1'b1; commit_en  = 1'b1; end
      default:   busy = 1'b0;
    endcase
  end

  // Datapath next state
  always_comb begin
    k_d       = k_q;
    guess_d   = guess_q;
    answer_d  = answer_q;
    row_d     = row_q;
    used_d    = used_q;
    fb_d      = fb_q;
    last_fb_d = last_fb_q;
    fb_flat_d = fb_flat_q;
    solved_d  = solved_q;
    done_d    = commit_en;

    if (capture_en) begin
      guess_d  = guess_i;
      answer_d = answer_i;
      row_d    = row_i;
      used_d   = '0;
      fb_d     = '0;
      k_d      = '0;
    end

    // k wraps 3 -> 0 on its own, which is exactly the restart the partial pass needs.
    if (exact_en || partial_en) begin
      k_d = k_q + PEG_IDX_W'(1);
    end

    if (exact_en && (g_k == a_k) && (g_k != COLOR_NONE)) begin
      fb_d[{k_q, 1'b0} +: FB_W] = FB_EXACT;
      used_d[k_q]               = 1'b1;
    end

    if (partial_en && (fb_k != FB_EXACT)) begin
      if (match_found) begin
        fb_d[{k_q, 1'b0} +: FB_W] = FB_PRESENT;
        used_d[match_idx]         = 1'b1;
      end else begin
        fb_d[{k_q, 1'b0} +: FB_W] = FB_ABSENT;
      end
    end

    if (commit_en) begin
      if (row_q < ROW_LIMIT) begin
        fb_flat_d[{row_q, 3'b000} +: FB_ROW_W] = fb_q;
      end
      last_fb_d = fb_q;
      if (fb_q == FB_ALL_EXACT) begin
        solved_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset_db) begin
    if (reset_db) begin
      k_q       <= '0;
      guess_q   <= '0;
      answer_q  <= '0;
      row_q     <= '0;
      used_q    <= '0;
      fb_q      <= '0;
      done_q    <= 1'b0;
      solved_q  <= 1'b0;
      last_fb_q <= '0;
      fb_flat_q <= '0;
    end else begin
      k_q       <= k_d;
      guess_q   <= guess_d;
      answer_q  <= answer_d;
      row_q     <= row_d;
      used_q    <= used_d;
      fb_q      <= fb_d;
      done_q    <= done_d;
      solved_q  <= solved_d;
      last_fb_q <= last_fb_d;
      fb_flat_q <= fb_flat_d;
    end
  end

  assign busy_o    = busy;
  assign done_o    = done_q;
  assign solved_o  = solved_q;
  assign last_fb_o = last_fb_q;
  assign fb_flat_o = fb_flat_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Scoreboard bench for mastermind_scorer: expected feedback is queued at start and
// checked against last_fb/fb_flat/solved when done pulses.
module tb_mastermind_scorer;

  typedef struct {
    logic [7:0] fb;
    logic [2:0] row;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        reset_db;
  logic        start;
  logic [11:0] guess;
  logic [11:0] answer;
  logic [2:0]  row;
  logic        busy;
  logic        done;
  logic        solved;
  logic [7:0]  last_fb;
  logic [47:0] fb_flat;

  exp_t        sb[$];
  logic [47:0] exp_flat;
  logic        exp_solved;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  mastermind_scorer dut (
    .sys_clk   (sys_clk),
    .reset_db  (reset_db),
    .start_i   (start),
    .guess_i   (guess),
    .answer_i  (answer),
    .row_i     (row),
    .busy_o    (busy),
    .done_o    (done),
    .solved_o  (solved),
    .last_fb_o (last_fb),
    .fb_flat_o (fb_flat)
  );

  function automatic logic [11:0] pack(int p0, int p1, int p2, int p3);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  // Colour-count reference: exact pegs first, then present pegs consume remaining counts.
  function automatic logic [7:0] model_score(logic [11:0] g, logic [11:0] a);
    int         cnt[8];
    bit         ex[4];
    logic [7:0] fb;
    logic [2:0] gi, ai;
    fb = '0;
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    for (int i = 0; i < 4; i++) begin
      gi = g[3*i +: 3];
      ai = a[3*i +: 3];
      ex[i] = (gi == ai) && (gi != 3'd0);
      if (ex[i]) fb[2*i +: 2] = 2'b11;
      else if (ai != 3'd0) cnt[ai]++;
    end
    for (int i = 0; i < 4; i++) begin
      gi = g[3*i +: 3];
      if (!ex[i]) begin
        if (gi != 3'd0 && cnt[gi] > 0) begin
          fb[2*i +: 2] = 2'b10;
          cnt[gi]--;
        end else begin
          fb[2*i +: 2] = 2'b01;
        end
      end
    end
    return fb;
  endfunction

  task automatic issue(input logic [11:0] g, input logic [11:0] a, input logic [2:0] r);
    exp_t e;
    @(negedge sys_clk);
    guess  = g;
    answer = a;
    row    = r;
    start  = 1'b1;
    e.fb   = model_score(g, a);
    e.row  = r;
    sb.push_back(e);
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  // Entered one negedge after the start cycle; done is due at count 10.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge sys_clk);
      cyc++;
    end
  endtask

  task automatic pop_model(output logic [7:0] fb);
    exp_t e;
    if (sb.size() == 0) begin
      fb = 'x;
    end else begin
      e  = sb.pop_front();
      fb = e.fb;
      if (e.row < 3'd6) exp_flat[8*e.row +: 8] = e.fb;
      if (e.fb == 8'hFF) exp_solved = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_db = 1'b1;
    start = 1'b0; guess = '0; answer = '0; row = '0;
    exp_flat = '0; exp_solved = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if ({busy, done, solved, last_fb} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got busy=%b done=%b solved=%b last_fb=%h exp all 0",
               busy, done, solved, last_fb);
    end
    n_tests++;
    if (fb_flat !== 48'd0) begin
      n_fail++; $display("FAIL reset_flat got %h exp 0", fb_flat);
    end
    reset_db = 1'b0;
  endtask

  task automatic test_absent();
    int cyc; logic [7:0] efb;
    issue(pack(2, 3, 4, 5), pack(1, 1, 1, 1), 3'd0);
    wait_done(cyc);
    pop_model(efb);
    n_tests++;
    if (cyc !== 10) begin n_fail++; $display("FAIL absent_latency got %0d exp 10", cyc); end
    n_tests++;
    if (fb_flat[7:0] !== 8'h55) begin
      n_fail++; $display("FAIL absent_row0 got %h exp 55", fb_flat[7:0]);
    end
    n_tests++;
    if (fb_flat[47:8] !== 40'd0) begin
      n_fail++; $display("FAIL absent_other_rows got %h exp 0", fb_flat[47:8]);
    end
    n_tests++;
    if (solved !== 1'b0 || last_fb !== efb) begin
      n_fail++; $display("FAIL absent_state got solved=%b last_fb=%h exp 0/%h", solved, last_fb, efb);
    end
  endtask

  task automatic test_duplicates();
    int cyc; logic [7:0] efb;
    issue(pack(1, 2, 1, 1), pack(1, 1, 2, 3), 3'd1);
    wait_done(cyc);
    pop_model(efb);
    n_tests++;
    if (fb_flat[15:8] !== 8'h6B) begin
      n_fail++; $display("FAIL dup_row1 got %h exp 6b", fb_flat[15:8]);
    end
    n_tests++;
    if (fb_flat !== exp_flat || last_fb !== efb) begin
      n_fail++; $display("FAIL dup_matrix got %h/%h exp %h/%h", fb_flat, last_fb, exp_flat, efb);
    end
  endtask

  task automatic test_color_zero();
    int cyc; logic [7:0] efb;
    issue(12'd0, 12'd0, 3'd4);
    wait_done(cyc);
    pop_model(efb);
    n_tests++;
    if (last_fb !== 8'h55 || solved !== 1'b0) begin
      n_fail++; $display("FAIL zero_score got last_fb=%h solved=%b exp 55/0", last_fb, solved);
    end
    n_tests++;
    if (fb_flat !== exp_flat) begin
      n_fail++; $display("FAIL zero_matrix got %h exp %h", fb_flat, exp_flat);
    end
    issue(pack(3, 4, 1, 1), pack(1, 4, 0, 2), 3'd7);
    wait_done(cyc);
    pop_model(efb);
    n_tests++;
    if (cyc !== 10 || last_fb !== efb) begin
      n_fail++; $display("FAIL row7_done got cyc=%0d last_fb=%h exp 10/%h", cyc, last_fb, efb);
    end
    n_tests++;
    if (fb_flat !== exp_flat) begin
      n_fail++; $display("FAIL row7_matrix got %h exp %h", fb_flat, exp_flat);
    end
  endtask

  task automatic test_win();
    int cyc; logic [7:0] efb;
    issue(pack(3, 5, 2, 6), pack(3, 5, 2, 6), 3'd2);
    wait_done(cyc);
    pop_model(efb);
    n_tests++;
    if (fb_flat[23:16] !== 8'hFF || last_fb !== 8'hFF || solved !== 1'b1) begin
      n_fail++;
      $display("FAIL win got row2=%h last_fb=%h solved=%b exp ff/ff/1",
               fb_flat[23:16], last_fb, solved);
    end
    issue(pack(6, 2, 5, 3), pack(3, 5, 2, 6), 3'd3);
    wait_done(cyc);
    pop_model(efb);
    n_tests++;
    if (solved !== exp_solved || fb_flat !== exp_flat || last_fb !== efb) begin
      n_fail++;
      $display("FAIL win_sticky got solved=%b flat=%h last=%h exp %b/%h/%h",
               solved, fb_flat, last_fb, exp_solved, exp_flat, efb);
    end
  endtask

  task automatic test_overwrite();
    int cyc; logic [7:0] efb;
    issue(pack(1, 1, 2, 2), pack(2, 1, 1, 2), 3'd0);
    wait_done(cyc);
    pop_model(efb);
    n_tests++;
    if (fb_flat !== exp_flat || last_fb !== efb) begin
      n_fail++; $display("FAIL overwrite got %h/%h exp %h/%h", fb_flat, last_fb, exp_flat, efb);
    end
  endtask

  task automatic test_back_to_back();
    int n_done, done_at, busy_bad;
    logic [7:0] efb;
    exp_t e;
    n_done = 0; done_at = -1; busy_bad = 0;
    @(negedge sys_clk);
    guess = pack(4, 2, 4, 1); answer = pack(4, 4, 1, 2); row = 3'd5; start = 1'b1;
    e.fb = model_score(pack(4, 2, 4, 1), pack(4, 4, 1, 2));
    e.row = 3'd5;
    sb.push_back(e);
    for (int c = 1; c <= 18; c++) begin
      @(negedge sys_clk);
      if (busy !== ((c >= 1) && (c <= 9))) busy_bad++;
      if (done === 1'b1) begin n_done++; done_at = c; end
      if (c == 1) start = 1'b0;
      if (c == 2) begin guess = pack(7, 7, 7, 7); answer = pack(7, 7, 7, 7); row = 3'd4; end
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
    end
    pop_model(efb);
    n_tests++;
    if (n_done !== 1 || done_at !== 10) begin
      n_fail++; $display("FAIL b2b_done got count=%0d at=%0d exp 1 at 10", n_done, done_at);
    end
    n_tests++;
    if (busy_bad !== 0) begin
      n_fail++; $display("FAIL b2b_busy got %0d bad cycles exp 0", busy_bad);
    end
    n_tests++;
    if (last_fb !== efb || fb_flat !== exp_flat || solved !== exp_solved) begin
      n_fail++;
      $display("FAIL b2b_result got %h/%h/%b exp %h/%h/%b",
               last_fb, fb_flat, solved, efb, exp_flat, exp_solved);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n_done; logic [7:0] efb;
    n_done = 0;
    issue(pack(1, 2, 3, 4), pack(1, 2, 3, 4), 3'd1);
    repeat (4) @(negedge sys_clk);
    reset_db = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, solved, last_fb} !== 11'd0 || fb_flat !== 48'd0) begin
      n_fail++;
      $display("FAIL midreset got busy=%b done=%b solved=%b last=%h flat=%h exp all 0",
               busy, done, solved, last_fb, fb_flat);
    end
    sb.delete();
    exp_flat = '0;
    exp_solved = 1'b0;
    @(negedge sys_clk);
    reset_db = 1'b0;
    repeat (15) begin
      @(negedge sys_clk);
      if (done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done !== 0) begin
      n_fail++; $display("FAIL midreset_ghost got %0d done pulses exp 0", n_done);
    end
    issue(pack(2, 2, 3, 1), pack(1, 2, 2, 3), 3'd3);
    wait_done(cyc);
    pop_model(efb);
    n_tests++;
    if (cyc !== 10 || last_fb !== efb || fb_flat !== exp_flat) begin
      n_fail++;
      $display("FAIL after_reset got cyc=%0d last=%h flat=%h exp 10/%h/%h",
               cyc, last_fb, fb_flat, efb, exp_flat);
    end
  endtask

  task automatic test_random();
    int cyc; logic [7:0] efb; logic [11:0] g, a;
    for (int i = 0; i < 10; i++) begin
      g = pack($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3));
      a = pack($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3));
      issue(g, a, 3'($urandom_range(0, 7)));
      wait_done(cyc);
      pop_model(efb);
      n_tests++;
      if (cyc !== 10 || last_fb !== efb || fb_flat !== exp_flat || solved !== exp_solved) begin
        n_fail++;
        $display("FAIL random_%0d g=%h a=%h got cyc=%0d last=%h flat=%h solved=%b exp %h/%h/%b",
                 i, g, a, cyc, last_fb, fb_flat, solved, efb, exp_flat, exp_solved);
      end
    end
  endtask

  initial begin
    test_reset();
    test_absent();
    test_duplicates();
    test_color_zero();
    test_win();
    test_overwrite();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
- Sequential Wordle-style scorer, sitting directly downstream of the game FSM's check state.
- Fires once per submitted guess. Compares the 4-peg guess against the secret answer with duplicate-correct rules.
- Produces per-peg feedback: exact, present or absent.
- Stores feedback in a 6-row feedback matrix, exported as a flat bus to the VGA renderer, plus a sticky solved flag for the FSM and renderer.

Parameters:
- N_PEGS, 4: pegs per guess.
- COLOR_W, 3: bits per peg colour code. Code 0 means "unselected/gray".
- N_ROWS, 6: guess rows stored.

Ports:
- sys_clk  in  1  system clock.
- reset_db  in  1  reset.
- start  in  1  1-cycle strobe (driven from q_Check); sampled only in IDLE.
- guess  in  12  current guess; peg i at [3i+2:3i].
- answer  in  12  secret answer; same packing.
- row  in  3  destination row (guess number).
- busy  out  1  high from the cycle after start is accepted through COMMIT.
- done  out  1  1-cycle pulse; fb_flat/solved already updated when high.
- solved  out  1  sticky; set when any committed row is all-exact.
- last_fb  out  8  feedback of most recent scored guess; peg i at [2i+1:2i].
- fb_flat  out  48  row r at [8r +: 8].

Reset and clocking (already decided):
- Reset reset_db, asynchronous, active-high; clock sys_clk.

Behaviour:
- Feedback code per peg:
  - 00 = unscored/empty
  - 01 = absent
  - 10 = present (wrong position)
  - 11 = exact
- Reset values: busy=0, done=0, solved=0, last_fb=0, fb_flat=0, FSM=IDLE, all internal scratch regs 0.
- FSM states: IDLE, EXACT, PARTIAL, COMMIT.
- IDLE:
  - On start=1, capture guess, answer and row into holding regs.
  - Clear the per-slot "used" mask (4 bits) and the working feedback.
  - Set peg index k=0 and go to EXACT.
  - start=0: stay in IDLE.
- EXACT, one peg per cycle, k=0..3:
  - If g[k]==a[k] and g[k]!=0: fb[k]=11 and used[k]=1.
  - After k=3, reset k=0 and go to PARTIAL.
- PARTIAL, one peg per cycle, k=0..3:
  - If fb[k]==11: unchanged.
  - Else find the lowest index j with used[j]=0, a[j]==g[k] and g[k]!=0. If found: fb[k]=10, used[j]=1. Otherwise fb[k]=01.
  - After k=3, go to COMMIT.
- COMMIT, 1 cycle:
  - If row<N_ROWS, write fb to fb_flat[8*row +: 8].
  - last_fb=fb.
  - If fb==8'hFF, solved<=1.
  - done registered high for the next cycle; return to IDLE.
- Latency:
  - Start accepted at edge T; EXACT occupies T+1..T+4, PARTIAL T+5..T+8, COMMIT T+9.
  - done=1 and the new fb_flat are visible in cycle T+10.
  - busy=1 for cycles T+1..T+9.
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - Captured inputs are frozen; changes to guess/answer/row during busy have no effect.
  - row>=N_ROWS: no matrix write; last_fb and done still update; solved still evaluated.
  - Rewrite of an already-filled row overwrites it.
  - Colour 0 on either side never matches. An all-zero guess scores 8'h55.
  - solved is never cleared except by reset_db.
  - reset_db mid-operation: immediate return to reset values, in-flight result discarded.

Decomposition:
- Shared package (mastermind_pkg): FB_EMPTY/FB_ABSENT/FB_PRESENT/FB_EXACT codes, N_PEGS, COLOR_W, N_ROWS, COLOR_NONE=0, state encodings (shared with the game core).
- One natural sub-module: mastermind_match_find. Combinational lowest-index search over unused answer slots; returns found flag and 2-bit index.

Test Plan:
- Answer 1,1,1,1; guess 2,3,4,5; row 0 → done at T+10; fb_flat[7:0]=8'h55; solved=0; other rows 0.
- Answer 3,5,2,6; guess 3,5,2,6; row 2 → fb_flat[23:16]=8'hFF; last_fb=8'hFF; solved=1 and stays 1 after a later non-winning guess.
- Duplicates: answer p0..p3=1,1,2,3; guess 1,2,1,1; row 1 → fb 11,10,10,01, i.e. fb_flat[15:8]=8'h6B.
- Colour 0: answer 0,0,0,0; guess 0,0,0,0 → 8'h55, solved=0. Row=7 with any guess → fb_flat unchanged, done pulses, last_fb updated.
- Timing and hold: start at T, second start at T+3 and guess changed at T+2 → single done at T+10, busy high T+1..T+9, result uses guess sampled at T.
- reset_db asserted at T+5 → busy, done, last_fb and fb_flat all 0 immediately. No done pulse afterwards. A new start after release scores normally.
